// File: rtl/dc_traffic_checker_pkg.sv
// Shared types and constants for the traffic checker: source FSM states,
// default parameter values and the counter width.
package dc_tb_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_PAT_W   = 16;
   localparam int DEF_TIMEOUT = 64;
   localparam int CNT_W       = 32;

   typedef enum logic {
      SRC_IDLE = 1'b0,
      SRC_PEND = 1'b1
   } src_state_e;

   // Saturating increment for the wide transfer counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dc_traffic_checker_if.sv
// Stream signals between the checker and the block under test: enq carries
// words into that block, deq carries them back out to the checker.
interface dc_traffic_checker_if #(parameter int WIDTH = 8);

   // Both streams: an item moves in any cycle where valid and ready are both
   // high; once valid is raised it must stay high with stable bits until ready.
   logic             io_enq_valid;
   logic             io_enq_ready;
   logic [WIDTH-1:0] io_enq_bits;
   logic             io_deq_valid;
   logic             io_deq_ready;
   logic [WIDTH-1:0] io_deq_bits;

   modport master (
      output io_enq_valid, io_enq_bits, io_deq_ready,
      input  io_enq_ready, io_deq_valid, io_deq_bits
   );

   modport slave (
      input  io_enq_valid, io_enq_bits, io_deq_ready,
      output io_enq_ready, io_deq_valid, io_deq_bits
   );

endinterface

// File: rtl/dc_traffic_checker_throttle.sv
// Rotating throttle pattern: loads the seed while in reset, then rotates left
// one bit per cycle; bit 0 is the live throttle decision.
module dc_pattern_throttle #(
   parameter int PAT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [PAT_W-1:0] pat_init,
   output logic             throttle
);

   logic [PAT_W-1:0] pat_q;

   always_ff @(posedge clock) begin
      if (reset) pat_q <= pat_init;
      else       pat_q <= {pat_q[PAT_W-2:0], pat_q[PAT_W-1]};
   end

   assign throttle = pat_q[0];

endmodule

// File: rtl/dc_traffic_checker.sv
// Traffic generator and checker: sources a {color, seq} counting stream,
// checks the returned stream for order, color, handshake rules and stalls.
module dc_traffic_checker
   import dc_tb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PAT_W   = DEF_PAT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_run,
   input  logic [PAT_W-1:0]     io_src_pat,
   input  logic [PAT_W-1:0]     io_dst_pat,
   dc_traffic_checker_if.master bus,
   output logic                 io_color_error,
   output logic                 io_seq_error,
   output logic                 io_proto_error,
   output logic                 io_timeout_error,
   output logic [CNT_W-1:0]     io_xfer_count,
   output src_state_e           io_src_state
);

   logic             src_bit, dst_bit;
   src_state_e       state_q, state_d;
   logic [WIDTH-1:0] src_word_q, exp_word_q, held_bits_q;
   logic             held_stall_q, deq_ready_q;
   logic [CNT_W-1:0] out_cnt_q, xfer_q;
   logic [15:0]      wd_q;
   logic             enq_fire, deq_fire, wd_clear;

   dc_pattern_throttle #(.PAT_W(PAT_W)) u_src_throttle (
      .clock(clock), .reset(reset), .pat_init(io_src_pat), .throttle(src_bit)
   );

   dc_pattern_throttle #(.PAT_W(PAT_W)) u_dst_throttle (
      .clock(clock), .reset(reset), .pat_init(io_dst_pat), .throttle(dst_bit)
   );

   assign enq_fire = bus.io_enq_valid && bus.io_enq_ready;
   assign deq_fire = bus.io_deq_valid && bus.io_deq_ready;
   assign wd_clear = deq_fire || (out_cnt_q == '0);

   always_ff @(posedge clock) begin
      if (reset) state_q <= SRC_IDLE;
      else       state_q <= state_d;
   end

   // A pending word is never withdrawn, even if io_run drops.
   always_comb begin
      state_d          = state_q;
      bus.io_enq_valid = 1'b0;
      case (state_q)
         SRC_IDLE: if (io_run && src_bit) state_d = SRC_PEND;
         SRC_PEND: begin
            bus.io_enq_valid = 1'b1;
            if (bus.io_enq_ready) state_d = SRC_IDLE;
         end
         default: state_d = SRC_IDLE;
      endcase
   end

   assign bus.io_enq_bits  = src_word_q;
   assign bus.io_deq_ready = deq_ready_q;
   assign io_xfer_count    = xfer_q;
   assign io_src_state     = state_q;

   // {color, seq} advances as one WIDTH-bit counter: color toggles on seq wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         src_word_q       <= '0;
         exp_word_q       <= '0;
         held_bits_q      <= '0;
         held_stall_q     <= 1'b0;
         deq_ready_q      <= 1'b0;
         out_cnt_q        <= '0;
         xfer_q           <= '0;
         wd_q             <= '0;
         io_color_error   <= 1'b0;
         io_seq_error     <= 1'b0;
         io_proto_error   <= 1'b0;
         io_timeout_error <= 1'b0;
      end else begin
         deq_ready_q  <= dst_bit;
         held_stall_q <= bus.io_deq_valid && !bus.io_deq_ready;
         held_bits_q  <= bus.io_deq_bits;

         if (enq_fire) src_word_q <= src_word_q + 1'b1;

         if (deq_fire) begin
            exp_word_q <= exp_word_q + 1'b1;
            xfer_q     <= sat_inc(xfer_q);
            if (bus.io_deq_bits[WIDTH-2:0] != exp_word_q[WIDTH-2:0])
               io_seq_error <= 1'b1;
            else if (bus.io_deq_bits[WIDTH-1] != exp_word_q[WIDTH-1])
               io_color_error <= 1'b1;
         end

         if (held_stall_q && (!bus.io_deq_valid || bus.io_deq_bits != held_bits_q))
            io_proto_error <= 1'b1;

         if (enq_fire && !deq_fire)      out_cnt_q <= out_cnt_q + 1'b1;
         else if (deq_fire && !enq_fire) out_cnt_q <= out_cnt_q - 1'b1;

         // Flag lands on the cycle the watchdog value reaches TIMEOUT.
         if (wd_clear) begin
            wd_q <= '0;
         end else begin
            if (wd_q != 16'(TIMEOUT)) wd_q <= wd_q + 1'b1;
            if (wd_q == 16'(TIMEOUT - 1)) io_timeout_error <= 1'b1;
         end
      end
   end

endmodule
